// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the async FIFO pointer logic.
//   bin2gray()          binary -> reflected Gray code
//   gray2bin()          reflected Gray -> binary (XOR prefix)
//   ptr_params_legal()  elaboration-time legality test for pointer parameters
// The helpers work on a fixed maximum word; callers zero-extend their
// PTR_WIDTH+1 pointer into it and truncate the result back. Zero upper bits
// do not change either conversion.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned GRAY_MAX_W = 32'd32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1'b1);
   endfunction

   // Prefix XOR by doubling shift distances: bit i becomes XOR of g[MSB:i].
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b = g;
      for (int s = 32'sd1; s < int'(GRAY_MAX_W); s = s << 1) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

   // The full compare needs the top two pointer bits and the lower bits,
   // so PTR_WIDTH must be at least 2. The pointer must also fit the helpers.
   function automatic bit ptr_params_legal(input int ptr_width, input int afull_thresh);
      return (ptr_width >= 32'sd2) &&
             (ptr_width < int'(GRAY_MAX_W) - 32'sd1) &&
             (afull_thresh >= 32'sd0) &&
             (afull_thresh < (32'sd1 << ptr_width));
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Combinational Gray -> binary converter (XOR prefix from the MSB down).
//   gray  in   WIDTH   Gray-coded value
//   bin   out  WIDTH   binary equivalent; bin[i] = ^gray[WIDTH-1:i]
// -----------------------------------------------------------------------------
module fifo_gray2bin #(
   parameter int WIDTH = 7
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each binary bit is the parity of the Gray bits at and above it.
   always_comb begin
      bin = '0;
      for (int i = 32'sd0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule : fifo_gray2bin

// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Write-domain pointer and flag generator of the async FIFO (transmit end of
// the pointer crossing).
//   clk               in   1            write-domain clock
//   resetn            in   1            synchronous active-low reset
//   wr_valid          in   1            producer has a word to write
//   wr_ready          out  1            ~full & resetn
//   wr_en_mem         out  1            RAM write strobe, wr_valid & wr_ready
//   wr_addr           out  PTR_WIDTH    RAM write address (low bits of wbin)
//   wr_ptr_gray       out  PTR_WIDTH+1  registered Gray write pointer
//   rd_ptr_gray_sync  in   PTR_WIDTH+1  read Gray pointer synchronized to clk
//   full              out  1            registered full flag
//   almost_full       out  1            registered, free entries <= AFULL_THRESH
//   wr_free           out  PTR_WIDTH+1  registered free-entry count 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH    = 6,
   parameter int AFULL_THRESH = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic                 wr_en_mem,
   output logic [PTR_WIDTH-1:0] wr_addr,
   output logic [PTR_WIDTH:0]   wr_ptr_gray,
   input  logic [PTR_WIDTH:0]   rd_ptr_gray_sync,
   output logic                 full,
   output logic                 almost_full,
   output logic [PTR_WIDTH:0]   wr_free
);

   localparam int                 PW          = PTR_WIDTH + 32'sd1;
   localparam int                 DEPTH       = 32'sd1 << PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] DEPTH_C     = PW'(DEPTH);
   localparam logic [PTR_WIDTH:0] AFULL_C     = PW'(AFULL_THRESH);
   localparam logic               AFULL_RST_C = (DEPTH <= AFULL_THRESH);

   if (!ptr_params_legal(PTR_WIDTH, AFULL_THRESH)) begin : g_illegal_params
      $error("fifo_wptr_full: PTR_WIDTH must be >= 2 and AFULL_THRESH in 0..DEPTH-1");
   end

   logic [PTR_WIDTH:0] wbin_r;
   logic [PTR_WIDTH:0] rbin_s;
   logic [PTR_WIDTH:0] wbin_next_s;
   logic [PTR_WIDTH:0] wgray_next_s;
   logic [PTR_WIDTH:0] rgray_full_s;
   logic [PTR_WIDTH:0] used_next_s;
   logic [PTR_WIDTH:0] free_next_s;
   logic               push_s;
   logic               full_next_s;
   logic               afull_next_s;

   fifo_gray2bin #(
      .WIDTH (PW)
   ) u_rd_gray2bin (
      .gray (rd_ptr_gray_sync),
      .bin  (rbin_s)
   );

   // Handshake outputs; gated by resetn so nothing is accepted during reset.
   always_comb begin
      wr_ready  = ~full & resetn;
      wr_en_mem = wr_valid & wr_ready;
      wr_addr   = wbin_r[PTR_WIDTH-1:0];
   end

   // Next-state pointer and flag computation. The read pointer and a push in
   // the same cycle are both folded in here, so neither is lost.
   always_comb begin
      push_s       = wr_valid & ~full;
      wbin_next_s  = wbin_r + {{PTR_WIDTH{1'b0}}, push_s};
      wgray_next_s = PW'(bin2gray(GRAY_MAX_W'(wbin_next_s)));
      // Full when the write pointer is exactly one lap ahead: in Gray code
      // that is the read pointer with its top two bits inverted.
      rgray_full_s = {~rd_ptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1],
                      rd_ptr_gray_sync[PTR_WIDTH-2:0]};
      full_next_s  = (wgray_next_s == rgray_full_s);
      used_next_s  = wbin_next_s - rbin_s;
      free_next_s  = DEPTH_C - used_next_s;
      afull_next_s = (free_next_s <= AFULL_C);
   end

   // State registers; the Gray pointer is registered so the crossing sees a
   // glitch-free value that moves at most one bit per clk.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wbin_r      <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         almost_full <= AFULL_RST_C;
         wr_free     <= DEPTH_C;
      end else begin
         wbin_r      <= wbin_next_s;
         wr_ptr_gray <= wgray_next_s;
         full        <= full_next_s;
         almost_full <= afull_next_s;
         wr_free     <= free_next_s;
      end
   end

endmodule : fifo_wptr_full
